// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU unified-memory port arbiter.
//   state_t            : arbiter FSM states (IDLE, IF_ACC, DM_ACC, DONE)
//   REQ_IF / REQ_DM    : requester identifiers used for grant/owner tracking
//   DEF_ADDR_W/DATA_W  : default address and data widths
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Grant selection between fetch and data requesters plus the saturating
// streak counter that bounds how many data grants may pass a waiting fetch.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   arb_en          : arbitration is being taken this cycle (arbiter idle)
//   if_req, dm_req  : requests from fetch and data ports
//   grant           : some requester would be granted
//   grant_id        : REQ_IF or REQ_DM, function of (if_req, dm_req, streak)
module arb_streak_ctr
  import cpu_mem_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant,
  output logic grant_id
);

  localparam int STREAK_W = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;
  logic                streak_full;

  assign streak_full = (streak_reg == STREAK_MAX);

  // Data wins a tie unless it has already passed a waiting fetch
  // MAX_DM_STREAK times in a row.
  always_comb begin
    grant    = if_req | dm_req;
    grant_id = REQ_IF;
    if (dm_req && !(if_req && streak_full)) begin
      grant_id = REQ_DM;
    end
  end

  // Streak only counts data grants that actually overtook a pending fetch;
  // a data grant with no fetch waiting starts a fresh window.
  always_comb begin
    streak_next = streak_reg;
    if (arb_en && grant) begin
      if (grant_id == REQ_IF || !if_req) begin
        streak_next = '0;
      end else if (!streak_full) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the CPU fetch
// port and data port, returns registered read data to the issuing port and
// generates the pipeline stall.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   if_req/if_addr                    : fetch request (held until if_done)
//   if_done/if_rdata                  : fetch completion pulse, fetch data
//   dm_req/dm_we/dm_addr/dm_wdata     : data request (held until dm_done)
//   dm_done/dm_rdata                  : data completion pulse, read data
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory command
//   mem_rdata/mem_ready               : memory response
//   cpu_stall                         : hold PC / pipeline registers
//   err_timeout                       : sticky access-timeout flag
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              cpu_stall,
  output logic              err_timeout
);

  localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t             state_reg;
  logic               owner_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               arb_en;
  logic               grant;
  logic               grant_id;
  logic               timer_last;

  assign arb_en = (state_reg == IDLE);

  // The current wait cycle is the TIMEOUT-th one without mem_ready.
  assign timer_last = (timer_reg == TIMER_W'(TIMEOUT - 1));

  arb_streak_ctr #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant   (grant),
    .grant_id(grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= REQ_IF;
      timer_reg   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            owner_reg <= grant_id;
            timer_reg <= '0;
            mem_req   <= 1'b1;
            if (grant_id == REQ_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              state_reg <= DM_ACC;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              state_reg <= IF_ACC;
            end
          end
        end
        IF_ACC, DM_ACC: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            state_reg <= DONE;
            if (state_reg == IF_ACC) begin
              if_rdata <= mem_rdata;
            end else if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
            if (timer_last) begin
              // Abort: the requester still gets its done pulse, with zero
              // read data and the sticky error flag raised.
              mem_req     <= 1'b0;
              err_timeout <= 1'b1;
              state_reg   <= DONE;
              if (state_reg == IF_ACC) begin
                if_rdata <= '0;
              end else if (!mem_we) begin
                dm_rdata <= '0;
              end
            end
          end
        end
        DONE: begin
          // No arbitration here, giving the requester one cycle to drop or
          // replace its request before the next grant.
          timer_reg <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign if_done = (state_reg == DONE) && (owner_reg == REQ_IF);
  assign dm_done = (state_reg == DONE) && (owner_reg == REQ_DM);

  // Gated by rst so the pipeline is released the moment reset is applied,
  // even while a requester still holds its request.
  assign cpu_stall = ~rst & ((if_req & ~if_done) | (dm_req & ~dm_done));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port and its data port.
- Arbitrates between the two requesters and sequences each access through a req/ready handshake to memory, where the memory has variable latency.
- Returns a registered read result to the requester that issued the access.
- Produces the pipeline-wide stall signal that the CPU uses to hold its PC and pipeline registers.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- MAX_DM_STREAK, 4, maximum back-to-back data grants while a fetch is pending; after that, fetch is forced.
- TIMEOUT, 255, cycles an access may wait for mem_ready before it is aborted with an error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  registered fetch data.
- dm_req  in  1  data request; held until dm_done.
- dm_we  in  1  1 = write, 0 = read; stable while dm_req.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_done  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DATA_W  registered read data; unchanged on writes.
- mem_req  out  1  memory access active; held until mem_ready.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  access complete this cycle.
- cpu_stall  out  1  combinational: (if_req & ~if_done) | (dm_req & ~dm_done).
- err_timeout  out  1  sticky; set on any timeout, cleared only by rst.

Behaviour:
- Reset:
  - state IDLE; streak and timer 0.
  - All outputs 0, including if_rdata, dm_rdata and the mem_* registers.
  - Reset asserted mid-access abandons the access; mem_req drops asynchronously.
- FSM states: IDLE, IF_ACC, DM_ACC, DONE.
- IDLE arbitration (evaluated each cycle):
  - Only one of if_req/dm_req high: grant that one.
  - Both high: grant dm, unless streak == MAX_DM_STREAK, in which case grant if.
  - On grant, register addr/we/wdata into mem_*, set mem_req = 1, go to IF_ACC or DM_ACC.
  - Fetch grants always drive mem_we = 0.
- Streak counter:
  - Incremented on a dm grant while if_req is high.
  - Cleared on any if grant, or on a dm grant while if_req is low.
  - Saturates at MAX_DM_STREAK.
- In IF_ACC/DM_ACC, each cycle:
  - mem_ready = 1: capture mem_rdata into if_rdata or dm_rdata (dm_rdata only if read), drop mem_req, go to DONE.
  - mem_ready = 0: increment timer.
  - timer == TIMEOUT: drop mem_req, set err_timeout, capture 0 into rdata, go to DONE.
- DONE:
  - Pulse if_done or dm_done for exactly one cycle.
  - Clear timer; return to IDLE.
- New grant timing:
  - No new grant is issued in DONE, so the requester can deassert or update its request.
  - Earliest next grant is the cycle after DONE.
- Latency, measured from the req edge at cycle 0 with zero-wait memory (mem_ready high at cycle 1):
  - mem_req high at cycle 1.
  - done at cycle 2.
  - Next grant at cycle 3.
  - Minimum 3 cycles per access.
- mem_ready while mem_req = 0 is ignored.
- A requester that drops req mid-access is a protocol violation; the access still completes and done still pulses.
- Addresses are passed through unmodified; there is no word/byte translation.

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum (IDLE, IF_ACC, DM_ACC, DONE);
  - requester ID constants REQ_IF = 0, REQ_DM = 1;
  - default ADDR_W/DATA_W.
- One natural sub-module, arb_streak_ctr: the saturating streak counter plus grant-select logic, pure function of (if_req, dm_req, streak).
- FSM, timer and data registers stay in the top.

Test Plan:
- Fetch only: if_req=1, if_addr=0x10, mem_ready on first cycle with mem_rdata=0x20080005 -> mem_req cycle 1 with mem_addr=0x10, mem_we=0; if_done cycle 2 with if_rdata=0x20080005; cpu_stall high cycles 0-1, low cycle 2.
- Simultaneous requests: if_req=1 and dm_req=1 (write, dm_addr=0x4, dm_wdata=0xDEAD) at cycle 0 -> dm granted first with mem_we=1, mem_wdata=0xDEAD; dm_done cycle 2; if granted cycle 3; if_done cycle 5.
- Starvation guard: dm_req re-asserted immediately after each dm_done, if_req held continuously -> exactly 4 dm grants, then if grant; streak=0 afterwards.
- Wait states: mem_ready delayed 3 cycles -> mem_req held 4 cycles; done exactly one cycle after mem_ready; dm_rdata captured from mem_rdata in the mem_ready cycle.
- Timeout with TIMEOUT=8: mem_ready never asserted -> mem_req drops after 8 wait cycles; err_timeout=1 and stays 1; dm_done pulses with dm_rdata=0; next request served normally.
- Reset mid-access: rst asserted in DM_ACC -> mem_req, dm_done and cpu_stall low immediately; after release, state IDLE and the first request behaves as in the fetch-only scenario.
